// File: rtl/csr_pkg.sv
`timescale 1ns/1ps
// csr_pkg
//  Shared definitions for the CSR access sequencer: SPI command opcodes,
//  the framing FSM state encoding, sticky error bit positions and the
//  arbiter grant indices.
//  Ports: none (package).
package csr_pkg;

    // Opcode field in bits [7:6] of an SPI command byte
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Command framing FSM
    typedef enum logic [1:0] {
        S_CMD    = 2'd0,  // waiting for a command byte
        S_DATA   = 2'd1,  // write command seen, waiting for its data byte
        S_PEND   = 2'd2,  // framed command waiting for its RAM slot
        S_RDWAIT = 2'd3   // read issued, RAM data returns this cycle
    } state_t;

    // Bit positions inside the sticky err vector
    localparam int ERR_BAD_CMD = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_TIMEOUT = 2;

    // Requester slots on the 2-way arbiter
    localparam int GNT_SPI = 0;
    localparam int GNT_INT = 1;

endpackage

// File: rtl/csr_rr_arb2.sv
`timescale 1ns/1ps
// csr_rr_arb2
//  Two-way round-robin arbiter. A lone requester is granted in the same
//  cycle; when both request, the one that was not granted most recently
//  wins. The last-grant flop resets to the internal slot so the SPI side
//  wins the first tie after reset.
//  Ports:
//   clk, rst   clock, asynchronous active-high reset
//   req[1:0]   request vector (GNT_SPI / GNT_INT slots)
//   gnt[1:0]   one-hot grant, combinational from req and last-grant
import csr_pkg::*;

module csr_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_int;  // 1: internal slot received the most recent grant

    always_comb begin
        gnt = 2'b00;
        if (req[GNT_SPI] && req[GNT_INT]) begin
            if (last_int) gnt[GNT_SPI] = 1'b1;
            else          gnt[GNT_INT] = 1'b1;
        end else if (req[GNT_SPI]) begin
            gnt[GNT_SPI] = 1'b1;
        end else if (req[GNT_INT]) begin
            gnt[GNT_INT] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_int <= 1'b1;
        else if (|gnt) last_int <= gnt[GNT_INT];
    end

endmodule

// File: rtl/csr_access_sched.sv
`timescale 1ns/1ps
// csr_access_sched
//  Sequences every access to the single-port CSR RAM. SPI bytes are framed
//  into commands ({op[1:0],addr[5:0]} plus a data byte for writes) and
//  arbitrated round-robin against the internal status-writeback requester.
//  Read data is returned to SPI or the internal port; protocol problems
//  are collected in a sticky error vector.
//
//  Optional feature: define CSR_FRAME_TIMEOUT_EN to abandon a write whose
//  data byte does not arrive within TIMEOUT cycles (sets err[2]). Without
//  it the FSM waits in S_DATA indefinitely and err[2] stays 0.
//
//  Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   spi_byte, spi_vld        received SPI byte and its 1-cycle strobe
//   spi_rsp, spi_rsp_vld     read data to SPI and its 1-cycle strobe
//   int_req/we/addr/wdata    internal request (held until int_gnt)
//   int_gnt                  internal access issued this cycle
//   int_rdata, int_rvld      internal read data, 1 cycle after int_gnt
//   csr_en/we/addr/wdata     CSR RAM access, combinational from the grant
//   csr_rdata                RAM read data, 1 cycle after a read
//   err                      sticky {timeout, overrun, bad_cmd}
//
//  Handshake: int_req is a level request held until int_gnt; int_gnt is a
//  one-cycle acknowledgement that the access was issued in that cycle, and
//  int_req may drop (or present the next request) on the following cycle.
//  spi_vld is a strobe with no back-pressure: bytes arriving while a
//  command is still in flight are dropped and flagged as overrun.
import csr_pkg::*;

module csr_access_sched #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] spi_byte,
    input  logic                  spi_vld,
    output logic [DATA_WIDTH-1:0] spi_rsp,
    output logic                  spi_rsp_vld,
    input  logic                  int_req,
    input  logic                  int_we,
    input  logic [ADDR_WIDTH-1:0] int_addr,
    input  logic [DATA_WIDTH-1:0] int_wdata,
    output logic                  int_gnt,
    output logic [DATA_WIDTH-1:0] int_rdata,
    output logic                  int_rvld,
    output logic                  csr_en,
    output logic                  csr_we,
    output logic [ADDR_WIDTH-1:0] csr_addr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic [2:0]            err
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state, state_nxt;
    logic                  cmd_we;      // framed command is a write
    logic [ADDR_WIDTH-1:0] cmd_addr;    // held through S_RDWAIT for rsp gating
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  cmd_ld, data_ld;
    logic [2:0]            err_q, err_set;
    logic                  err_clr;
    logic                  int_rd_pend, int_rd_bad;
    logic [1:0]            req, gnt;
    logic                  spi_addr_bad, int_addr_bad;
    logic [1:0]            spi_op;

    assign spi_op       = spi_byte[DATA_WIDTH-1 -: 2];
    assign spi_addr_bad = {1'b0, cmd_addr} >= DEPTH_LIM;
    assign int_addr_bad = {1'b0, int_addr} >= DEPTH_LIM;

    assign req[GNT_SPI] = (state == S_PEND);
    assign req[GNT_INT] = int_req;

    csr_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

`ifdef CSR_FRAME_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] to_cnt;  // cycles spent in S_DATA; held at 0 elsewhere

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  to_cnt <= '0;
        else if (state != S_DATA) to_cnt <= '0;
        else                      to_cnt <= to_cnt + 8'd1;
    end
`endif

    // Next state, command capture strobes and error events
    always_comb begin
        state_nxt = state;
        cmd_ld    = 1'b0;
        data_ld   = 1'b0;
        err_set   = '0;
        err_clr   = 1'b0;
        case (state)
            S_CMD: begin
                if (spi_vld) begin
                    case (spi_op)
                        OP_WRITE: begin
                            state_nxt = S_DATA;
                            cmd_ld    = 1'b1;
                        end
                        OP_READ: begin
                            state_nxt = S_PEND;
                            cmd_ld    = 1'b1;
                        end
                        OP_RSVD: err_set[ERR_BAD_CMD] = 1'b1;
                        OP_NOP:  err_clr = (spi_byte == '0);
                        default: err_clr = 1'b0;
                    endcase
                end
            end
            S_DATA: begin
                if (spi_vld) begin
                    state_nxt = S_PEND;
                    data_ld   = 1'b1;
                end
`ifdef CSR_FRAME_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    state_nxt             = S_CMD;
                    err_set[ERR_TIMEOUT]  = 1'b1;
                end
`endif
            end
            S_PEND: begin
                err_set[ERR_OVERRUN] = spi_vld;
                if (gnt[GNT_SPI]) state_nxt = cmd_we ? S_CMD : S_RDWAIT;
            end
            S_RDWAIT: begin
                err_set[ERR_OVERRUN] = spi_vld;
                state_nxt            = S_CMD;
            end
            default: state_nxt = S_CMD;
        endcase
        // Out-of-range accesses are still granted (keeps the timing of the
        // response strobes) but never reach the RAM.
        if ((gnt[GNT_SPI] && spi_addr_bad) || (gnt[GNT_INT] && int_addr_bad))
            err_set[ERR_BAD_CMD] = 1'b1;
    end

    // RAM port driven straight from the grant of this cycle
    always_comb begin
        csr_en    = 1'b0;
        csr_we    = 1'b0;
        csr_addr  = '0;
        csr_wdata = '0;
        if (gnt[GNT_SPI] && !spi_addr_bad) begin
            csr_en    = 1'b1;
            csr_we    = cmd_we;
            csr_addr  = cmd_addr;
            csr_wdata = cmd_we ? cmd_wdata : '0;
        end else if (gnt[GNT_INT] && !int_addr_bad) begin
            csr_en    = 1'b1;
            csr_we    = int_we;
            csr_addr  = int_addr;
            csr_wdata = int_we ? int_wdata : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_CMD;
            cmd_we      <= 1'b0;
            cmd_addr    <= '0;
            cmd_wdata   <= '0;
            err_q       <= '0;
            int_rd_pend <= 1'b0;
            int_rd_bad  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cmd_ld) begin
                cmd_we   <= (spi_op == OP_WRITE);
                cmd_addr <= spi_byte[ADDR_WIDTH-1:0];
            end
            if (data_ld) cmd_wdata <= spi_byte;
            // A new error in the same cycle as a clear survives the clear
            err_q       <= err_clr ? err_set : (err_q | err_set);
            int_rd_pend <= gnt[GNT_INT] & ~int_we;
            int_rd_bad  <= int_addr_bad;
        end
    end

    assign int_gnt     = gnt[GNT_INT];
    assign int_rvld    = int_rd_pend;
    assign int_rdata   = (int_rd_pend && !int_rd_bad) ? csr_rdata : '0;
    assign spi_rsp_vld = (state == S_RDWAIT);
    assign spi_rsp     = (state == S_RDWAIT && !spi_addr_bad) ? csr_rdata : '0;
    assign err         = err_q;

endmodule

// File: tb/tb_csr_access_sched.sv
`timescale 1ns/1ps
// tb_csr_access_sched
//  Directed and randomized checks of csr_access_sched against a
//  transaction-level reference: a reference memory, an expected error
//  vector and expected queues of RAM accesses and read responses.
//  Honours CSR_FRAME_TIMEOUT_EN (bench then uses TIMEOUT = 4).
module tb_csr_access_sched;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
`ifdef CSR_FRAME_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 255;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] spi_byte;
    logic          spi_vld;
    logic [DW-1:0] spi_rsp;
    logic          spi_rsp_vld;
    logic          int_req;
    logic          int_we;
    logic [AW-1:0] int_addr;
    logic [DW-1:0] int_wdata;
    logic          int_gnt;
    logic [DW-1:0] int_rdata;
    logic          int_rvld;
    logic          csr_en;
    logic          csr_we;
    logic [AW-1:0] csr_addr;
    logic [DW-1:0] csr_wdata;
    logic [DW-1:0] csr_rdata = 8'h00;
    logic [2:0]    err;

    always #5 clk = ~clk;

    csr_access_sched #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .TIMEOUT    (TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_byte    (spi_byte),
        .spi_vld     (spi_vld),
        .spi_rsp     (spi_rsp),
        .spi_rsp_vld (spi_rsp_vld),
        .int_req     (int_req),
        .int_we      (int_we),
        .int_addr    (int_addr),
        .int_wdata   (int_wdata),
        .int_gnt     (int_gnt),
        .int_rdata   (int_rdata),
        .int_rvld    (int_rvld),
        .csr_en      (csr_en),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .err         (err)
    );

    // CSR RAM attached to the DUT, one-cycle read latency
    logic [DW-1:0] ram [0:63] = '{default: 8'h00};
    always @(posedge clk) begin
        if (csr_en) begin
            if (csr_we) ram[csr_addr] <= csr_wdata;
            else        csr_rdata     <= ram[csr_addr];
        end
    end

    // ---------------- reference model state ----------------
    logic [DW-1:0] ref_mem [0:63] = '{default: 8'h00};
    logic [2:0]    exp_err = 3'b000;
    logic [14:0]   exp_acc_q[$];   // {we, addr, wdata (0 for reads)}
    logic [7:0]    exp_rsp_q[$];   // SPI read responses
    logic [7:0]    exp_int_q[$];   // internal read responses

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [14:0] e;
        logic [7:0]  r;
        if (csr_en) begin
            if (exp_acc_q.size() == 0) begin
                check("acc_unexpected", {17'd0, csr_en, csr_we, csr_addr, csr_wdata}, 32'd0);
            end else begin
                e = exp_acc_q.pop_front();
                check("acc", {17'd0, csr_we, csr_addr, (csr_we ? csr_wdata : 8'h00)}, {17'd0, e});
            end
        end
        if (spi_rsp_vld) begin
            if (exp_rsp_q.size() == 0) begin
                check("rsp_unexpected", {23'd0, spi_rsp_vld, spi_rsp}, 32'd0);
            end else begin
                r = exp_rsp_q.pop_front();
                check("spi_rsp", spi_rsp, r);
            end
        end
        if (int_rvld) begin
            if (exp_int_q.size() == 0) begin
                check("irsp_unexpected", {23'd0, int_rvld, int_rdata}, 32'd0);
            end else begin
                r = exp_int_q.pop_front();
                check("int_rdata", int_rdata, r);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic spi_send(input logic [7:0] b);
        spi_byte = b;
        spi_vld  = 1'b1;
        tick();
        spi_vld  = 1'b0;
        spi_byte = 8'h00;
    endtask

    function automatic logic addr_ok(input logic [5:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic [5:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 6'($urandom_range(32, 63));
        return 6'($urandom_range(0, 31));
    endfunction

    task automatic expect_spi_write(input logic [5:0] a, input logic [7:0] d);
        if (addr_ok(a)) begin
            exp_acc_q.push_back({1'b1, a, d});
            ref_mem[a] = d;
        end else begin
            exp_err[0] = 1'b1;
        end
    endtask

    task automatic expect_spi_read(input logic [5:0] a);
        if (addr_ok(a)) begin
            exp_acc_q.push_back({1'b0, a, 8'h00});
            exp_rsp_q.push_back(ref_mem[a]);
        end else begin
            exp_err[0] = 1'b1;
            exp_rsp_q.push_back(8'h00);
        end
    endtask

    task automatic spi_write(input logic [5:0] a, input logic [7:0] d);
        expect_spi_write(a, d);
        spi_send({2'b10, a});
        spi_send(d);
        idle(3);
    endtask

    task automatic spi_read(input logic [5:0] a);
        expect_spi_read(a);
        spi_send({2'b01, a});
        idle(3);
    endtask

    task automatic int_access(input logic we, input logic [5:0] a, input logic [7:0] d);
        if (addr_ok(a)) begin
            exp_acc_q.push_back({we, a, (we ? d : 8'h00)});
            if (we) ref_mem[a] = d;
            else    exp_int_q.push_back(ref_mem[a]);
        end else begin
            exp_err[0] = 1'b1;
            if (!we) exp_int_q.push_back(8'h00);
        end
        int_req   = 1'b1;
        int_we    = we;
        int_addr  = a;
        int_wdata = d;
        @(negedge clk);
        check("int_gnt_solo", int_gnt, 1'b1);
        tick();
        int_req = 1'b0;
        idle(2);
    endtask

    task automatic spi_ctl(input logic [7:0] b);
        if (b[7:6] == 2'b11)  exp_err[0] = 1'b1;
        else if (b == 8'h00)  exp_err    = 3'b000;
        spi_send(b);
        idle(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] a;
        logic [7:0] d;
        int         kind;

        rst = 1'b1; spi_vld = 1'b0; spi_byte = 8'h00;
        int_req = 1'b0; int_we = 1'b0; int_addr = '0; int_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_csr_en", csr_en, 1'b0);
        check("rst_outs", {spi_rsp_vld, int_gnt, int_rvld, csr_we}, 4'b0000);
        check("rst_data", {spi_rsp, int_rdata, csr_addr, csr_wdata}, 30'd0);
        check("rst_err", err, 3'b000);
        tick();
        rst = 1'b0;
        idle(1);

        // Preload two words through the internal port
        int_access(1'b1, 6'd5, 8'h5A);
        int_access(1'b1, 6'd7, 8'h7B);

        // First tie after reset: SPI wins, internal next cycle
        expect_spi_read(6'd5);
        exp_acc_q.push_back({1'b0, 6'd7, 8'h00});
        exp_int_q.push_back(ref_mem[7]);
        spi_send(8'h45);
        int_req = 1'b1; int_we = 1'b0; int_addr = 6'd7;
        @(negedge clk);
        check("tie1_int_gnt", int_gnt, 1'b0);
        check("tie1_spi_addr", {csr_en, csr_addr}, {1'b1, 6'd5});
        tick();
        @(negedge clk);
        check("tie1_int_gnt2", int_gnt, 1'b1);
        check("tie1_int_addr", {csr_en, csr_addr}, {1'b1, 6'd7});
        tick();
        int_req = 1'b0;
        idle(3);

        // After an SPI-only grant, the next tie goes to internal first
        spi_read(6'd2);
        exp_acc_q.push_back({1'b0, 6'd9, 8'h00});
        exp_int_q.push_back(ref_mem[9]);
        expect_spi_read(6'd6);
        spi_send(8'h46);
        int_req = 1'b1; int_we = 1'b0; int_addr = 6'd9;
        @(negedge clk);
        check("tie2_int_gnt", int_gnt, 1'b1);
        check("tie2_int_addr", csr_addr, 6'd9);
        tick();
        int_req = 1'b0;
        @(negedge clk);
        check("tie2_spi_addr", {int_gnt, csr_en, csr_addr}, {1'b0, 1'b1, 6'd6});
        idle(4);

        // Write 83,A5: RAM write one cycle after the data strobe
        expect_spi_write(6'd3, 8'hA5);
        spi_send(8'h83);
        spi_send(8'hA5);
        @(negedge clk);
        check("wr_timing", {csr_en, csr_we, csr_addr, csr_wdata}, {1'b1, 1'b1, 6'd3, 8'hA5});
        idle(3);

        // Read 43: RAM read at N+1, response at N+2
        expect_spi_read(6'd3);
        spi_send(8'h43);
        @(negedge clk);
        check("rd_issue", {csr_en, csr_we, csr_addr, spi_rsp_vld}, {1'b1, 1'b0, 6'd3, 1'b0});
        tick();
        @(negedge clk);
        check("rd_rsp", {spi_rsp_vld, spi_rsp}, {1'b1, 8'hA5});
        idle(3);

        // Reserved op sets bad_cmd without a RAM access; 00 clears
        spi_ctl(8'hC1);
        check("bad_cmd", err, 3'b001);
        spi_ctl(8'h00);
        check("nop_clear", err, 3'b000);

        // Byte during S_RDWAIT is dropped and flags overrun
        expect_spi_read(6'd3);
        spi_send(8'h43);
        tick();
        spi_send(8'h8F);
        idle(3);
        exp_err[1] = 1'b1;
        check("overrun", err, 3'b010);
        spi_ctl(8'h00);

        // Out-of-range accesses from both sources
        int_access(1'b0, 6'd40, 8'h00);
        check("int_bad_addr", err, exp_err);
        spi_read(6'd50);
        spi_write(6'd33, 8'h11);
        check("spi_bad_addr", err, exp_err);
        spi_ctl(8'h00);

        // Reset while a write waits for data and while a read is pending
        spi_send(8'h84);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        exp_err = 3'b000;
        idle(1);
        spi_read(6'd4);
        spi_send(8'h43);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_rd", {csr_en, spi_rsp_vld}, 2'b00);
        idle(2);
        rst = 1'b0;
        idle(2);
        check("rst_mid_err", err, 3'b000);

`ifdef CSR_FRAME_TIMEOUT_EN
        // Write command followed by silence: abandoned after TIMEOUT cycles
        spi_send(8'h85);
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            @(negedge clk);
            check("to_wait", err, 3'b000);
            tick();
        end
        @(negedge clk);
        exp_err[2] = 1'b1;
        check("to_set", err, 3'b100);
        idle(1);
        spi_read(6'd5);
        spi_ctl(8'h00);
        // Data arriving inside the window is accepted
        expect_spi_write(6'd6, 8'h33);
        spi_send(8'h86);
        idle(2);
        spi_send(8'h33);
        idle(3);
        check("to_ok", err, 3'b000);
`else
        // Without the timeout the data byte may arrive arbitrarily late
        spi_send(8'h85);
        idle(20);
        check("no_to_err", err, 3'b000);
        expect_spi_write(6'd5, 8'h3C);
        spi_send(8'h3C);
        idle(3);
`endif

        // Randomized transactions
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 4);
            a    = rand_addr();
            d    = 8'($urandom_range(0, 255));
            case (kind)
                0: spi_write(a, d);
                1: spi_read(a);
                2: int_access(1'b1, a, d);
                3: int_access(1'b0, a, d);
                default: begin
                    case ($urandom_range(0, 2))
                        0:       spi_ctl({2'b11, a});
                        1:       spi_ctl(8'h00);
                        default: spi_ctl({2'b00, a | 6'd1});
                    endcase
                end
            endcase
            check("rnd_err", err, exp_err);
        end

        idle(5);
        check("acc_q_empty", exp_acc_q.size(), 0);
        check("rsp_q_empty", exp_rsp_q.size(), 0);
        check("int_q_empty", exp_int_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
